// File: rtl/parity_serial_rx_if.sv
// Serial receive bundle: the line in, and the decoded byte with its status flags out.
// The master drives the line; the slave (receiver) reports completed frames.
interface parity_serial_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data_out,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output data_out,
    output valid,
    output parity_err,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/parity_serial_rx.sv
// 8-bit LSB-first serial receiver with one parity bit and one stop bit, sampled mid-bit.
// Result registers update one clock after the stop-bit sample; no backpressure, valid is a single-cycle pulse.
module parity_serial_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  parity_serial_rx_if.slave bus
);

  localparam int         CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic       ODD         = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          par_err_q;
  logic          armed_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          perr_q;
  logic          ferr_q;
  logic          busy_q;

  logic          bit_tick;
  logic [7:0]    shift_d;
  logic          par_err_d;

  assign bit_tick  = (cnt_q == '0);
  assign shift_d   = {bus.rx, shift_q[7:1]};
  assign par_err_d = (^shift_q) ^ bus.rx ^ ODD;

  // armed_q blocks a start detect until the line has been seen idle after reset,
  // so a low line at reset release is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.rx) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (armed_q && !bus.rx) begin
            state_q <= START;
            cnt_q   <= HALF_RELOAD;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (bit_tick) begin
            if (bus.rx) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
              cnt_q   <= BIT_RELOAD;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        // The 3-bit index rolls over to zero on the eighth bit, ready for the next frame.
        DATA: begin
          if (bit_tick) begin
            shift_q   <= shift_d;
            cnt_q     <= BIT_RELOAD;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= PARITY;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        PARITY: begin
          if (bit_tick) begin
            par_err_q <= par_err_d;
            cnt_q     <= BIT_RELOAD;
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        STOP: begin
          if (bit_tick) begin
            data_q  <= shift_q;
            perr_q  <= par_err_q;
            ferr_q  <= !bus.rx;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            if (bus.rx) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        BREAK: begin
          if (bus.rx) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/parity_serial_rx.md
PARITY_SERIAL_RX -- requirements
Module: parity_serial_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..1024.
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port rx  input  1: serial line, idle high, already synchronous to clk.
REQ-006 Port data_out  output  8: last received data byte, LSB received first.
REQ-007 Port valid  output  1: one-cycle pulse, frame complete.
REQ-008 Port parity_err  output  1: parity mismatch on the last completed frame.
REQ-009 Port frame_err  output  1: stop bit sampled low on the last completed frame.
REQ-010 Port busy  output  1: high in every state except IDLE.

Function
REQ-011 The frame SHALL be: start bit (0), data bits d0..d7 (LSB first), parity bit, stop bit (1); 11 bits total.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-013 IDLE SHALL move to START on the first rising edge at which rx=0; that edge is edge E0.
REQ-014 Let H = CLKS_PER_BIT/2 (integer division); sample k SHALL be taken at edge E0 + H + k*CLKS_PER_BIT. k=0 is the start bit, k=1..8 are d0..d7, k=9 is parity, k=10 is stop.
REQ-015 START, on sample 0: if rx=1 (glitch), return to IDLE with no valid and no output change; if rx=0, go to DATA.
REQ-016 DATA SHALL shift in 8 bits via a 3-bit bit index, then go to PARITY; the index SHALL wrap cleanly for the next frame.
REQ-017 PARITY SHALL compute P = XOR of d0..d7 XOR the parity bit XOR PARITY_ODD; P=1 is a parity error.
REQ-018 STOP: if the stop sample is 1, go to IDLE; if it is 0, go to BREAK.
REQ-019 BREAK SHALL wait for rx=1, then go to IDLE; no start detection occurs in BREAK.
REQ-020 On the edge after the stop sample, the block SHALL pulse valid high for exactly 1 cycle and load data_out, parity_err and frame_err simultaneously.
REQ-021 valid SHALL pulse even when parity_err or frame_err is set.
REQ-022 data_out, parity_err and frame_err SHALL hold their values until the next valid; no other event may change them except reset.
REQ-023 After a good stop bit, a start edge at the very next cycle in IDLE SHALL be accepted; back-to-back frames lose no data.
REQ-024 rx activity in the middle of a bit, between sample points, SHALL be ignored.
REQ-025 The bit-timing counter SHALL be sized as clog2(CLKS_PER_BIT) bits and reload on every sample point; no overflow is permitted.

Reset
REQ-026 While rst_n=0, the FSM SHALL be IDLE and the counters SHALL be zero.
REQ-027 While rst_n=0, outputs SHALL be: data_out=8'h00, valid=0, parity_err=0, frame_err=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no valid pulse.
REQ-029 After rst_n deasserts, the block SHALL wait for a new falling edge of rx before starting a frame.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-030 Good frame: 0xA5 with parity bit 0 and stop 1 -> data_out=8'hA5, valid pulses 1 cycle, parity_err=0, frame_err=0.
REQ-031 Parity error: 0x01 with parity bit 0 -> data_out=8'h01, parity_err=1, frame_err=0. With PARITY_ODD=1, the same frame gives parity_err=0.
REQ-032 Framing error: 0x3C with correct parity and stop bit 0, rx held low 3 extra bit times, then high -> frame_err=1, busy stays high until rx=1, no second valid.
REQ-033 Glitch: rx low for 1 cycle only -> block returns to IDLE, no valid, outputs unchanged.
REQ-034 Back-to-back: 0x55 then 0xFF with no idle gap -> two valid pulses, exactly 11*CLKS_PER_BIT cycles apart, with correct bytes.
REQ-035 Reset mid-frame: rst_n=0 during data bit d3 -> all outputs go to reset values asynchronously; the next full frame 0x81 is received correctly.
